// File: rtl/ipbus_reg_slave_if.sv
// IPbus transaction bundle between the upstream master fabric and a register slave.
// The master drives the request fields; the slave returns a one-cycle ack or err with read data.
interface ipbus_reg_slave_if;
  logic        ipb_strobe;
  logic        ipb_write;
  logic [31:0] ipb_addr;
  logic [31:0] ipb_wdata;
  logic        ipb_ack;
  logic        ipb_err;
  logic [31:0] ipb_rdata;

  modport master (
    output ipb_strobe, ipb_write, ipb_addr, ipb_wdata,
    input  ipb_ack, ipb_err, ipb_rdata
  );

  modport slave (
    input  ipb_strobe, ipb_write, ipb_addr, ipb_wdata,
    output ipb_ack, ipb_err, ipb_rdata
  );
endinterface

// File: rtl/ipbus_reg_slave.sv
// IPbus register slave in the clk125 domain: control bank, status window, scratch, ID and readout FIFO.
// Two-state responder: a request is decoded in IDLE and answered with a single ack or err pulse in RESP.
module ipbus_reg_slave #(
  parameter int          N_CTRL     = 8,
  parameter int          N_STAT     = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BLOCK_ID   = 32'h1B05_0001
) (
  input  logic                 clk125,
  input  logic                 rst_125,
  ipbus_reg_slave_if.slave     ipb,
  output logic [N_CTRL*32-1:0] ctrl_out,
  output logic [N_CTRL-1:0]    ctrl_wr,
  input  logic [N_STAT*32-1:0] stat_in,
  input  logic                 fifo_wr_en,
  input  logic [31:0]          fifo_wdata,
  output logic                 fifo_full,
  output logic                 fifo_overflow
);
  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_stat;
  logic        req_ok;
  logic [31:0] scratch;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        accept_ok;
  logic [31:0] stat_sel;
  logic [31:0] read_word;
  logic        pop;
  logic        push;
  logic        ovf_clr;
  logic        ovf_set;
  logic        addr_hi_unused;

  assign addr_hi_unused = ^ipb.ipb_addr[31:5];

  // Legality of the incoming request is settled at accept, including the empty-FIFO pop check.
  always_comb begin
    accept_ok = 1'b0;
    stat_sel  = '0;
    if (ipb.ipb_addr[4:3] == 2'b00) begin
      accept_ok = int'(ipb.ipb_addr[2:0]) < N_CTRL;
    end else if (ipb.ipb_addr[4:3] == 2'b01) begin
      accept_ok = !ipb.ipb_write && (int'(ipb.ipb_addr[2:0]) < N_STAT);
    end else begin
      case (ipb.ipb_addr[4:0])
        5'h10:   accept_ok = !ipb.ipb_write && (count != '0);
        5'h11:   accept_ok = !ipb.ipb_write;
        5'h12:   accept_ok = 1'b1;
        5'h13:   accept_ok = !ipb.ipb_write;
        default: accept_ok = 1'b0;
      endcase
    end
    for (int k = 0; k < N_STAT; k++) begin
      if (ipb.ipb_addr[2:0] == 3'(k)) stat_sel = stat_in[k*32 +: 32];
    end
  end

  always_comb begin
    read_word = '0;
    if (req_addr[4:3] == 2'b00) begin
      for (int k = 0; k < N_CTRL; k++) begin
        if (req_addr[2:0] == 3'(k)) read_word = ctrl_out[k*32 +: 32];
      end
    end else if (req_addr[4:3] == 2'b01) begin
      read_word = req_stat;
    end else begin
      case (req_addr)
        5'h10:   read_word = fifo_mem[rd_ptr];
        5'h11:   read_word = {fifo_overflow, 15'b0, 16'(count)};
        5'h12:   read_word = scratch;
        5'h13:   read_word = BLOCK_ID;
        default: read_word = '0;
      endcase
    end
  end

  assign fifo_full = (count == DEPTH_C);
  assign pop       = (state == RESP) && req_ok && !req_write && (req_addr == 5'h10);
  assign ovf_clr   = (state == RESP) && req_ok && !req_write && (req_addr == 5'h11);
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push      = fifo_wr_en && (!fifo_full || pop);
  assign ovf_set   = fifo_wr_en && fifo_full && !pop;

  always_ff @(posedge clk125) begin
    if (push) fifo_mem[wr_ptr] <= fifo_wdata;
  end

  always_ff @(posedge clk125) begin
    if (rst_125) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (ovf_set)      fifo_overflow <= 1'b1;
      else if (ovf_clr) fifo_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk125) begin
    if (rst_125) begin
      state         <= IDLE;
      req_write     <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      req_stat      <= '0;
      req_ok        <= 1'b0;
      scratch       <= '0;
      ctrl_out      <= '0;
      ctrl_wr       <= '0;
      ipb.ipb_ack   <= 1'b0;
      ipb.ipb_err   <= 1'b0;
      ipb.ipb_rdata <= '0;
    end else begin
      ipb.ipb_ack   <= 1'b0;
      ipb.ipb_err   <= 1'b0;
      ipb.ipb_rdata <= '0;
      ctrl_wr       <= '0;
      case (state)
        IDLE: begin
          if (ipb.ipb_strobe) begin
            req_write <= ipb.ipb_write;
            req_addr  <= ipb.ipb_addr[4:0];
            req_wdata <= ipb.ipb_wdata;
            req_stat  <= stat_sel;
            req_ok    <= accept_ok;
            state     <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
          if (req_ok) begin
            ipb.ipb_ack <= 1'b1;
            if (req_write) begin
              if (req_addr == 5'h12) scratch <= req_wdata;
              for (int k = 0; k < N_CTRL; k++) begin
                if (req_addr == 5'(k)) begin
                  ctrl_out[k*32 +: 32] <= req_wdata;
                  ctrl_wr[k]           <= 1'b1;
                end
              end
            end else begin
              ipb.ipb_rdata <= read_word;
            end
          end else begin
            ipb.ipb_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ipbus_reg_slave.sv
// Self-checking bench for ipbus_reg_slave: directed scenarios plus randomized traffic
// compared against a register/queue model of the address map and readout FIFO.
module tb_ipbus_reg_slave;
  localparam int          N_CTRL     = 8;
  localparam int          N_STAT     = 8;
  localparam int          FIFO_DEPTH = 16;
  localparam logic [31:0] BLOCK_ID   = 32'h1B05_0001;

  logic                 clk125;
  logic                 rst_125;
  logic [N_CTRL*32-1:0] ctrl_out;
  logic [N_CTRL-1:0]    ctrl_wr;
  logic [N_STAT*32-1:0] stat_in;
  logic                 fifo_wr_en;
  logic [31:0]          fifo_wdata;
  logic                 fifo_full;
  logic                 fifo_overflow;

  ipbus_reg_slave_if ipb ();

  ipbus_reg_slave #(
    .N_CTRL(N_CTRL), .N_STAT(N_STAT), .FIFO_DEPTH(FIFO_DEPTH), .BLOCK_ID(BLOCK_ID)
  ) dut (
    .clk125(clk125), .rst_125(rst_125), .ipb(ipb.slave),
    .ctrl_out(ctrl_out), .ctrl_wr(ctrl_wr), .stat_in(stat_in),
    .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata),
    .fifo_full(fifo_full), .fifo_overflow(fifo_overflow)
  );

  initial clk125 = 1'b0;
  always #5 clk125 = ~clk125;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_ctrl [N_CTRL];
  logic [31:0] m_scratch;
  logic [31:0] m_fifo [$];
  logic        m_ovf;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [255:0] modelCtrlVec();
    logic [255:0] v = '0;
    for (int k = 0; k < N_CTRL; k++) v[k*32 +: 32] = m_ctrl[k];
    return v;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < N_CTRL; k++) m_ctrl[k] = '0;
    m_scratch = '0;
    m_fifo.delete();
    m_ovf = 1'b0;
  endtask

  function automatic void modelPush(input logic [31:0] d);
    if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(d);
    else m_ovf = 1'b1;
  endfunction

  task automatic doReset();
    @(negedge clk125);
    rst_125 = 1'b1;
    ipb.ipb_strobe = 1'b0;
    fifo_wr_en = 1'b0;
    repeat (2) @(negedge clk125);
    rst_125 = 1'b0;
    modelReset();
  endtask

  task automatic pushWord(input logic [31:0] d);
    @(negedge clk125);
    fifo_wr_en = 1'b1;
    fifo_wdata = d;
    @(negedge clk125);
    fifo_wr_en = 1'b0;
    modelPush(d);
  endtask

  // One complete bus transaction; optionally pushes a FIFO word on the response edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic push_in_resp, input logic [31:0] push_data);
    logic [4:0]  a;
    logic        ok;
    logic [31:0] rd;
    logic [7:0]  exp_wr;
    int          n;
    logic        got;
    a = addr[4:0];
    ok = 1'b0;
    rd = '0;
    if (int'(a) < 8) begin
      ok = int'(a) < N_CTRL;
      if (ok && !wr) rd = m_ctrl[a[2:0]];
    end else if (int'(a) < 16) begin
      ok = !wr && (int'(a) - 8 < N_STAT);
      if (ok) rd = stat_in[(int'(a) - 8)*32 +: 32];
    end else if (a == 5'h10) begin
      ok = !wr && (m_fifo.size() > 0);
      if (ok) rd = m_fifo[0];
    end else if (a == 5'h11) begin
      ok = !wr;
      if (ok) rd = {m_ovf, 15'b0, 16'(m_fifo.size())};
    end else if (a == 5'h12) begin
      ok = 1'b1;
      if (!wr) rd = m_scratch;
    end else if (a == 5'h13) begin
      ok = !wr;
      if (ok) rd = BLOCK_ID;
    end
    exp_wr = (wr && ok && int'(a) < 8) ? (8'd1 << a[2:0]) : 8'd0;

    @(negedge clk125);
    ipb.ipb_strobe = 1'b1;
    ipb.ipb_write  = wr;
    ipb.ipb_addr   = addr;
    ipb.ipb_wdata  = wdata;
    @(negedge clk125);
    ipb.ipb_strobe = 1'b0;
    checkOutput("no_early_resp", {ipb.ipb_ack, ipb.ipb_err}, 2'b00);
    // Request fields and status inputs move during RESP; the slave must ignore them.
    ipb.ipb_write = $urandom_range(0, 1);
    ipb.ipb_addr  = $urandom;
    ipb.ipb_wdata = $urandom;
    for (int k = 0; k < N_STAT; k++) stat_in[k*32 +: 32] = $urandom;
    if (push_in_resp) begin
      fifo_wr_en = 1'b1;
      fifo_wdata = push_data;
    end
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk125);
      fifo_wr_en = 1'b0;
      n++;
      if (ipb.ipb_ack || ipb.ipb_err) got = 1'b1;
    end
    checkOutput("resp_latency", n, 1);
    checkOutput("ack", ipb.ipb_ack, ok);
    checkOutput("err", ipb.ipb_err, !ok);
    checkOutput("rdata", ipb.ipb_rdata, rd);
    checkOutput("ctrl_wr_pulse", ctrl_wr, exp_wr);

    if (ok && wr) begin
      if (int'(a) < 8) m_ctrl[a[2:0]] = wdata;
      else m_scratch = wdata;
    end
    if (ok && !wr && a == 5'h10) void'(m_fifo.pop_front());
    if (ok && !wr && a == 5'h11) m_ovf = 1'b0;
    if (push_in_resp) modelPush(push_data);

    @(negedge clk125);
    checkOutput("ack_one_cycle", {ipb.ipb_ack, ipb.ipb_err}, 2'b00);
    checkOutput("ctrl_wr_clear", ctrl_wr, 8'd0);
    checkOutput("ctrl_out", ctrl_out, modelCtrlVec());
    checkOutput("fifo_full", fifo_full, m_fifo.size() == FIFO_DEPTH);
    checkOutput("fifo_overflow", fifo_overflow, m_ovf);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    logic exp_ack [8];
    rst_125        = 1'b1;
    ipb.ipb_strobe = 1'b0;
    ipb.ipb_write  = 1'b0;
    ipb.ipb_addr   = '0;
    ipb.ipb_wdata  = '0;
    fifo_wr_en     = 1'b0;
    fifo_wdata     = '0;
    for (int k = 0; k < N_STAT; k++) stat_in[k*32 +: 32] = $urandom;
    modelReset();

    doReset();
    checkOutput("rst_ack", ipb.ipb_ack, 1'b0);
    checkOutput("rst_err", ipb.ipb_err, 1'b0);
    checkOutput("rst_rdata", ipb.ipb_rdata, 32'd0);
    checkOutput("rst_ctrl_out", ctrl_out, '0);
    checkOutput("rst_ctrl_wr", ctrl_wr, 8'd0);
    checkOutput("rst_full", fifo_full, 1'b0);
    checkOutput("rst_ovf", fifo_overflow, 1'b0);

    $display("[TB] directed register accesses");
    applyStimulus(1'b0, 32'h13, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h12, 32'hDEAD_BEEF, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'hFFFF_FF12, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h03, 32'h5, 1'b0, 32'h0);
    checkOutput("ctrl3_word", ctrl_out[127:96], 32'h5);
    applyStimulus(1'b0, 32'h0B, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h09, 32'h1234_5678, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h1A, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h13, 32'h1111_1111, 1'b0, 32'h0);

    $display("[TB] FIFO fill, overflow and drain");
    for (int i = 0; i < 17; i++) begin
      pushWord(32'(i));
      if (i == 15) begin
        checkOutput("full_at_16", fifo_full, 1'b1);
        checkOutput("no_ovf_at_16", fifo_overflow, 1'b0);
      end
    end
    checkOutput("ovf_after_17", fifo_overflow, 1'b1);
    applyStimulus(1'b0, 32'h11, 32'h0, 1'b0, 32'h0);
    checkOutput("ovf_cleared", fifo_overflow, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b0, 32'h0);

    $display("[TB] simultaneous push/pop at full and empty");
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b1, 32'hCAFE_0001);
    applyStimulus(1'b0, 32'h11, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 15; i++) pushWord($urandom);
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b1, 32'hCAFE_0002);
    applyStimulus(1'b0, 32'h11, 32'h0, 1'b0, 32'h0);
    pushWord(32'hCAFE_0003);
    applyStimulus(1'b0, 32'h11, 32'h0, 1'b1, 32'hCAFE_0004);

    $display("[TB] back-to-back strobe");
    @(negedge clk125);
    ipb.ipb_strobe = 1'b1;
    ipb.ipb_write  = 1'b0;
    ipb.ipb_addr   = 32'h12;
    exp_ack = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk125);
      if (i == 5) ipb.ipb_strobe = 1'b0;
      checkOutput($sformatf("b2b_ack_%0d", i), ipb.ipb_ack, exp_ack[i]);
      checkOutput($sformatf("b2b_rdata_%0d", i), ipb.ipb_rdata, exp_ack[i] ? m_scratch : 32'd0);
    end

    $display("[TB] reset during response");
    @(negedge clk125);
    ipb.ipb_strobe = 1'b1;
    ipb.ipb_write  = 1'b1;
    ipb.ipb_addr   = 32'h00;
    ipb.ipb_wdata  = 32'hA5A5_A5A5;
    @(negedge clk125);
    ipb.ipb_strobe = 1'b0;
    rst_125 = 1'b1;
    @(negedge clk125);
    rst_125 = 1'b0;
    modelReset();
    checkOutput("rstresp_ack_err", {ipb.ipb_ack, ipb.ipb_err}, 2'b00);
    checkOutput("rstresp_ctrl_out", ctrl_out, '0);
    @(negedge clk125);
    checkOutput("rstresp_no_late", {ipb.ipb_ack, ipb.ipb_err}, 2'b00);
    applyStimulus(1'b0, 32'h13, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h00, 32'h0, 1'b0, 32'h0);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 150; t++) begin
      logic [31:0] addr;
      if ($urandom_range(0, 1) == 1) addr = 32'h10 + $urandom_range(0, 3);
      else addr = $urandom;
      if ($urandom_range(0, 2) == 0) pushWord($urandom);
      applyStimulus($urandom_range(0, 1) == 1, addr, $urandom,
                    $urandom_range(0, 3) == 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
